// File: rtl/dtl_console_uart_tx_if.sv
// Write-side sideband of the DTL console port as seen by the UART serializer.
// The master drives one word per cycle with per-lane byte enables; there is no
// stall signal, so the slave must accept or drop every offered word.
interface dtl_console_uart_tx_if #(
    parameter int unsigned INTERFACE_WIDTH       = 32,
    parameter int unsigned INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8
);
    logic                             writeValid;
    logic [INTERFACE_WIDTH-1:0]       writeData;
    logic [INTERFACE_NUM_ENABLES-1:0] writeEnable;

    modport master (
        output writeValid,
        output writeData,
        output writeEnable
    );

    modport slave (
        input writeValid,
        input writeData,
        input writeEnable
    );
endinterface

// File: rtl/dtl_console_uart_tx.sv
// Console output serializer: buffers DTL console words in a small FIFO and
// sends every enabled byte, lane 0 first, on an 8N1 UART line.
module dtl_console_uart_tx #(
    parameter int unsigned INTERFACE_WIDTH       = 32,
    parameter int unsigned INTERFACE_NUM_ENABLES = INTERFACE_WIDTH / 8,
    parameter int unsigned FIFO_DEPTH            = 8,
    parameter int unsigned CLKS_PER_BIT          = 434
) (
    input  logic                              iClk,
    input  logic                              iReset,
    dtl_console_uart_tx_if.slave              wr,
    input  logic                              iOverflowClear,
    output logic                              oTx,
    output logic                              oBusy,
    output logic                              oOverflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   oFifoLevel
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LaneW  = (INTERFACE_NUM_ENABLES > 1) ?
                                     $clog2(INTERFACE_NUM_ENABLES) : 1;
    localparam int unsigned BaudW  = $clog2(CLKS_PER_BIT);

    localparam logic [LevelW-1:0] LevelFull = LevelW'(FIFO_DEPTH);
    localparam logic [LaneW-1:0]  LaneLast  = LaneW'(INTERFACE_NUM_ENABLES - 1);
    localparam logic [BaudW-1:0]  BaudLast  = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLane,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [INTERFACE_WIDTH-1:0]       dataMem [FIFO_DEPTH];
    logic [INTERFACE_NUM_ENABLES-1:0] enMem   [FIFO_DEPTH];
    logic [PtrW-1:0]                  wrPtr;
    logic [PtrW-1:0]                  rdPtr;
    logic [LevelW-1:0]                level;
    logic                             overflow;

    logic fifoFull;
    logic fifoEmpty;
    logic push;
    logic drop;
    logic pop;

    state_e state;

    assign fifoFull  = (level == LevelFull);
    assign fifoEmpty = (level == '0);
    // Fullness is judged on the registered level, so a same-cycle pop never
    // makes room for the incoming word.
    assign push      = wr.writeValid && !fifoFull;
    assign drop      = wr.writeValid && fifoFull;
    assign pop       = (state == StIdle) && !fifoEmpty;

    // Storage array: written on push only, no reset needed.
    always_ff @(posedge iClk) begin
        if (push) begin
            dataMem[wrPtr] <= wr.writeData;
            enMem[wrPtr]   <= wr.writeEnable;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LevelW'(1);
                2'b01:   level <= level - LevelW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag; a drop wins over a same-cycle clear.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (iOverflowClear) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Lane walker and 8N1 serializer
    // ------------------------------------------------------------------
    logic [INTERFACE_WIDTH-1:0]       wordReg;
    logic [INTERFACE_NUM_ENABLES-1:0] enReg;
    logic [LaneW-1:0]                 lane;
    logic [7:0]                       shiftReg;
    logic [BaudW-1:0]                 baudCnt;
    logic [2:0]                       bitCnt;
    logic                             txReg;

    logic       laneIsLast;
    logic       laneEnabled;
    logic [7:0] laneByte;
    logic       baudDone;

    assign laneIsLast  = (lane == LaneLast);
    assign laneEnabled = enReg[lane];
    assign laneByte    = wordReg[8*lane +: 8];
    assign baudDone    = (baudCnt == BaudLast);

    // Frame sequencer: pops words, skips disabled lanes and drives the line register.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state    <= StIdle;
            wordReg  <= '0;
            enReg    <= '0;
            lane     <= '0;
            shiftReg <= '0;
            baudCnt  <= '0;
            bitCnt   <= '0;
            txReg    <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    baudCnt <= '0;
                    bitCnt  <= '0;
                    txReg   <= 1'b1;
                    if (!fifoEmpty) begin
                        wordReg <= dataMem[rdPtr];
                        enReg   <= enMem[rdPtr];
                        lane    <= '0;
                        state   <= StLane;
                    end
                end
                StLane: begin
                    baudCnt <= '0;
                    bitCnt  <= '0;
                    if (laneEnabled) begin
                        shiftReg <= laneByte;
                        txReg    <= 1'b0;
                        state    <= StStart;
                    end else if (laneIsLast) begin
                        state <= StIdle;
                    end else begin
                        lane <= lane + LaneW'(1);
                    end
                end
                StStart: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        txReg   <= shiftReg[0];
                        state   <= StData;
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                    end
                end
                StData: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (bitCnt == 3'd7) begin
                            bitCnt <= '0;
                            txReg  <= 1'b1;
                            state  <= StStop;
                        end else begin
                            // Present the next bit while shifting it into position 0.
                            bitCnt   <= bitCnt + 3'd1;
                            shiftReg <= shiftReg >> 1;
                            txReg    <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        if (laneIsLast) begin
                            state <= StIdle;
                        end else begin
                            lane  <= lane + LaneW'(1);
                            state <= StLane;
                        end
                    end else begin
                        baudCnt <= baudCnt + BaudW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    txReg <= 1'b1;
                end
            endcase
        end
    end

    assign oTx        = txReg;
    assign oBusy      = (state != StIdle) || !fifoEmpty;
    assign oOverflow  = overflow;
    assign oFifoLevel = level;

endmodule
